// File: rtl/bypass_scoreboard.sv
// Operand forwarding network for the ID stage with a long-latency scoreboard.
// Each ID source operand takes the youngest matching post-ID stage result,
// then a returning long-op result, then the register file. A stall is raised
// when the producing instruction exists but its data is not available yet.
module bypass_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_LONG = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic [NUM_STG-1:0]          stg_valid,
  input  logic [NUM_STG-1:0]          stg_we,
  input  logic [NUM_STG-1:0]          stg_dok,
  input  logic [NUM_STG*ADDR_W-1:0]   stg_waddr,
  input  logic [NUM_STG*DATA_W-1:0]   stg_wdata,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   src_rdata,
  output logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_stall,
  output logic                        stall,
  input  logic                        iss_valid,
  input  logic [ADDR_W-1:0]           iss_waddr,
  input  logic                        lng_done,
  input  logic [ADDR_W-1:0]           lng_waddr,
  input  logic [DATA_W-1:0]           lng_wdata,
  output logic                        long_full,
  output logic [31:0]                 stall_cnt
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_LONG + 1);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             iss_bad, done_bad;

  assign long_full = (cnt_q == CNT_W'(MAX_LONG));
  assign stall     = |src_stall;
  assign stall_cnt = stall_cnt_q;

  // An issue at full occupancy is only legal when a slot frees in the same cycle.
  assign iss_bad  = iss_valid & long_full & ~lng_done;
  assign done_bad = lng_done & (cnt_q == '0);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              st;
    logic              hit;

    assign a = src_addr[gi*ADDR_W +: ADDR_W];

    // Priority select: youngest stage, then returning long op, then pending, then RF.
    always_comb begin
      d   = '0;
      st  = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < NUM_STG; k++) begin
        if (!hit && stg_valid[k] && stg_we[k] &&
            (stg_waddr[k*ADDR_W +: ADDR_W] == a)) begin
          hit = 1'b1;
          if (stg_dok[k]) d = stg_wdata[k*DATA_W +: DATA_W];
          else            st = 1'b1;
        end
      end
      if (!hit) begin
        if (lng_done && (lng_waddr == a)) d = lng_wdata;
        else if (pending_q[a])             st = 1'b1;
        else                               d = src_rdata[gi*DATA_W +: DATA_W];
      end
      if (a == '0) begin
        d  = '0;
        st = 1'b0;
      end
    end

    assign src_data[gi*DATA_W +: DATA_W] = d;
    assign src_stall[gi]                 = st;
  end

  // Scoreboard next state; a set and clear of the same register resolve to set.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (flush) begin
      pending_d = '0;
      cnt_d     = '0;
    end else if (!iss_bad && !done_bad) begin
      if (lng_done) pending_d[lng_waddr] = 1'b0;
      if (iss_valid && (iss_waddr != '0)) pending_d[iss_waddr] = 1'b1;
      if (iss_valid && !lng_done)      cnt_d = cnt_q + CNT_W'(1);
      else if (!iss_valid && lng_done) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Saturating count of stalled cycles; survives flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q   <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Issue into a full table or a completion with nothing outstanding is a caller bug.
  a_legal_long : assert property (@(posedge clk) disable iff (!resetn)
    (flush || !(iss_bad || done_bad)));

endmodule
